// File: rtl/sort_stat.sv
// Frame statistics for the sorter output stream: max, min, median, range, trimmed mean,
// plus an on-line monotonicity check of the frame order.
module sort_stat #(
  parameter int DW   = 16,
  parameter int N    = 16,
  parameter int TRIM = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_vld,
  input  logic signed [DW-1:0] din,
  output logic                 stat_vld,
  output logic signed [DW-1:0] max_o,
  output logic signed [DW-1:0] min_o,
  output logic signed [DW-1:0] med_o,
  output logic        [DW:0]   range_o,
  output logic signed [DW-1:0] tmean_o,
  output logic                 sort_err,
  output logic                 busy
);

  localparam int CW = $clog2(N);
  localparam int AW = DW + CW;
  localparam int SH = $clog2(N - 2*TRIM);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_COLLECT = 2'd1;
  localparam logic [1:0] S_DONE    = 2'd2;
  localparam logic [1:0] S_LOCK    = 2'd3;

  localparam logic [1:0] D_UND = 2'd0;
  localparam logic [1:0] D_ASC = 2'd1;
  localparam logic [1:0] D_DSC = 2'd2;

  localparam logic [CW-1:0] I_TLO  = CW'(TRIM);
  localparam logic [CW-1:0] I_THI  = CW'(N-1-TRIM);
  localparam logic [CW-1:0] I_MLO  = CW'(N/2-1);
  localparam logic [CW-1:0] I_MHI  = CW'(N/2);
  localparam logic [CW-1:0] I_LAST = CW'(N-1);

  logic [1:0]           state;
  logic [CW-1:0]        cnt;
  logic signed [DW-1:0] run_max, run_min, prev;
  logic signed [DW:0]   med_sum;
  logic signed [AW-1:0] tsum;
  logic [1:0]           dir;
  logic                 err;

  logic                 acc, first;
  logic [CW-1:0]        idx;
  logic signed [DW-1:0] nxt_max, nxt_min;
  logic signed [DW:0]   nxt_med;
  logic signed [AW-1:0] nxt_tsum;
  logic [1:0]           nxt_dir;
  logic                 nxt_err;
  logic [DW:0]          nxt_rng;

  assign busy = (state == S_COLLECT);

  // Next running values with the current sample folded in, so the last sample's
  // contribution can be registered straight into the outputs.
  always_comb begin
    acc      = in_vld && (state == S_IDLE || state == S_COLLECT);
    idx      = (state == S_IDLE) ? '0 : cnt;
    first    = (idx == '0);
    nxt_max  = (first || din > run_max) ? din : run_max;
    nxt_min  = (first || din < run_min) ? din : run_min;
    nxt_tsum = first ? '0 : tsum;
    if (idx >= I_TLO && idx <= I_THI)
      nxt_tsum = nxt_tsum + {{CW{din[DW-1]}}, din};
    nxt_med = med_sum;
    if (idx == I_MLO)
      nxt_med = {din[DW-1], din};
    else if (idx == I_MHI)
      nxt_med = med_sum + {din[DW-1], din};
    nxt_dir = dir;
    nxt_err = err;
    if (first) begin
      nxt_dir = D_UND;
      nxt_err = 1'b0;
    end else if (din > prev) begin
      if (dir == D_DSC) nxt_err = 1'b1;
      else              nxt_dir = D_ASC;
    end else if (din < prev) begin
      if (dir == D_ASC) nxt_err = 1'b1;
      else              nxt_dir = D_DSC;
    end
    nxt_rng = {nxt_max[DW-1], nxt_max} - {nxt_min[DW-1], nxt_min};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      cnt      <= '0;
      run_max  <= '0;
      run_min  <= '0;
      prev     <= '0;
      med_sum  <= '0;
      tsum     <= '0;
      dir      <= D_UND;
      err      <= 1'b0;
      stat_vld <= 1'b0;
      max_o    <= '0;
      min_o    <= '0;
      med_o    <= '0;
      range_o  <= '0;
      tmean_o  <= '0;
      sort_err <= 1'b0;
    end else begin
      stat_vld <= 1'b0;
      case (state)
        S_IDLE:    if (in_vld) state <= S_COLLECT;
        S_COLLECT: if (in_vld && cnt == I_LAST) state <= S_DONE;
        S_DONE:    state <= S_LOCK;
        default:   if (!in_vld) state <= S_IDLE;
      endcase
      if (acc) begin
        cnt     <= idx + CW'(1);
        run_max <= nxt_max;
        run_min <= nxt_min;
        prev    <= din;
        med_sum <= nxt_med;
        tsum    <= nxt_tsum;
        dir     <= nxt_dir;
        err     <= nxt_err;
        // Results land in the DONE cycle, together with the stat_vld pulse.
        if (idx == I_LAST) begin
          stat_vld <= 1'b1;
          max_o    <= nxt_max;
          min_o    <= nxt_min;
          med_o    <= DW'(nxt_med >>> 1);
          range_o  <= nxt_rng;
          tmean_o  <= DW'(nxt_tsum >>> SH);
          sort_err <= nxt_err;
        end
      end
    end
  end

endmodule

// File: tb/tb_sort_stat.sv
// Randomized scoreboard bench for sort_stat: expected stats per frame are queued at issue
// time and compared by an independent monitor on every stat_vld pulse.
module tb_sort_stat;
  localparam int DW = 16, N = 16, TRIM = 4;

  logic                 clk = 1'b0;
  logic                 rst, in_vld;
  logic signed [DW-1:0] din;
  logic                 stat_vld, sort_err, busy;
  logic signed [DW-1:0] max_o, min_o, med_o, tmean_o;
  logic        [DW:0]   range_o;

  always #5 clk = ~clk;

  sort_stat #(.DW(DW), .N(N), .TRIM(TRIM)) dut (
    .clk(clk), .rst(rst), .in_vld(in_vld), .din(din), .stat_vld(stat_vld),
    .max_o(max_o), .min_o(min_o), .med_o(med_o), .range_o(range_o),
    .tmean_o(tmean_o), .sort_err(sort_err), .busy(busy));

  typedef struct { int mx; int mn; int md; int rg; int tm; int err; } exp_t;
  exp_t q[$];
  int   total = 0, bad = 0, pulses = 0, nframes = 0;
  int   fr[N];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  function automatic int fdiv(input int a, input int d);
    int r = a / d;
    if ((a % d) != 0 && a < 0) r--;
    return r;
  endfunction

  // Reference: stats straight from the definitions over the whole frame.
  function automatic exp_t model();
    exp_t e;
    int   mx = fr[0], mn = fr[0], sum = 0;
    bit   up = 1, dn = 1;
    for (int i = 0; i < N; i++) begin
      if (fr[i] > mx) mx = fr[i];
      if (fr[i] < mn) mn = fr[i];
      if (i > 0 && fr[i] < fr[i-1]) up = 0;
      if (i > 0 && fr[i] > fr[i-1]) dn = 0;
      if (i >= TRIM && i <= N-1-TRIM) sum += fr[i];
    end
    e.mx = mx; e.mn = mn; e.rg = mx - mn;
    e.md = fdiv(fr[N/2-1] + fr[N/2], 2);
    e.tm = fdiv(sum, N - 2*TRIM);
    e.err = (up || dn) ? 0 : 1;
    return e;
  endfunction

  task automatic send(input int gap_at, input int gap_len, input int tail, input bit rnd_gaps);
    q.push_back(model());
    nframes++;
    for (int i = 0; i < N; i++) begin
      if (rnd_gaps && i > 0)
        while ($urandom_range(0, 3) == 0) begin
          @(negedge clk); in_vld = 1'b0; din = DW'($urandom);
        end
      @(negedge clk); in_vld = 1'b1; din = DW'(fr[i]);
      if (i == gap_at)
        for (int g = 0; g < gap_len; g++) begin
          @(negedge clk); in_vld = 1'b0; din = DW'($urandom);
          if (g == 0) chk("busy_in_gap", int'(busy), 1);
        end
    end
    repeat (tail) begin @(negedge clk); in_vld = 1'b1; din = DW'($urandom); end
    repeat (tail == 0 ? 2 : 1) begin @(negedge clk); in_vld = 1'b0; end
  endtask

  task automatic rand_frame(input bit narrow);
    int tq[$];
    logic signed [DW-1:0] t;
    for (int i = 0; i < N; i++) begin
      t = DW'($urandom);
      tq.push_back(narrow ? int'($urandom_range(0, 6)) - 3 : int'(t));
    end
    tq.sort();
    if ($urandom_range(0, 1) == 1) tq.reverse();
    for (int i = 0; i < N; i++) fr[i] = tq[i];
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (stat_vld) begin
        pulses++;
        if (q.size() == 0) chk("unexpected_stat_vld", 1, 0);
        else begin
          e = q.pop_front();
          chk("max", int'(max_o), e.mx);
          chk("min", int'(min_o), e.mn);
          chk("med", int'(med_o), e.md);
          chk("range", int'(range_o), e.rg);
          chk("tmean", int'(tmean_o), e.tm);
          chk("sort_err", int'(sort_err), e.err);
        end
      end
    end
  end

  initial begin
    rst = 1'b1; in_vld = 1'b0; din = '0;
    repeat (3) @(negedge clk);
    chk("rst_stat_vld", int'(stat_vld), 0);
    chk("rst_max", int'(max_o), 0);
    chk("rst_min", int'(min_o), 0);
    chk("rst_med", int'(med_o), 0);
    chk("rst_range", int'(range_o), 0);
    chk("rst_tmean", int'(tmean_o), 0);
    chk("rst_err", int'(sort_err), 0);
    chk("rst_busy", int'(busy), 0);
    rst = 1'b0;

    for (int i = 0; i < N; i++) fr[i] = 15 - i;
    send(-1, 0, 20, 0);
    for (int i = 0; i < N; i++) fr[i] = i - 8;
    send(5, 3, 0, 0);
    for (int i = 0; i < N; i++) fr[i] = (i < 8) ? 32767 : -32768;
    send(-1, 0, 1, 0);
    for (int i = 0; i < N; i++) fr[i] = 15 - i;
    fr[9] = 5; fr[10] = 6;
    send(-1, 0, 0, 0);
    rand_frame(0);
    send(-1, 0, 24, 0);
    rand_frame(1);
    send(-1, 0, 0, 0);

    // Abandon a frame part-way with reset.
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); in_vld = 1'b1; din = DW'(100 + i);
    end
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0; in_vld = 1'b0;
    chk("midrst_max", int'(max_o), 0);
    chk("midrst_min", int'(min_o), 0);
    chk("midrst_range", int'(range_o), 0);
    chk("midrst_err", int'(sort_err), 0);
    chk("midrst_busy", int'(busy), 0);
    @(negedge clk);
    for (int i = 0; i < N; i++) fr[i] = 5;
    send(-1, 0, 0, 0);

    for (int k = 0; k < 24; k++) begin
      rand_frame($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 2) == 0) begin
        int p = int'($urandom_range(1, N-1));
        int t = fr[p];
        fr[p] = fr[p-1]; fr[p-1] = t;
      end
      send(-1, 0, int'($urandom_range(0, 3)), 1);
    end

    for (int k = 0; k < 50 && q.size() != 0; k++) @(negedge clk);
    chk("queue_drained", q.size(), 0);
    chk("pulse_count", pulses, nframes);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
